// File: rtl/regfl_fifo_ctrl.sv
// Sequencer that wraps a 2**AW x DW register file as a FIFO.
// The write side accepts on a valid/ready stream; the read side presents the file's combinational read data on a valid/ready stream.
module regfl_fifo_ctrl #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          rf_wr_e,
  output logic [AW-1:0] rf_wr_addr,
  output logic [DW-1:0] rf_wr_data,
  output logic [AW-1:0] rf_rd_addr,
  input  logic [DW-1:0] rf_rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 2 ** AW;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push;
  logic          pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Write enable is masked by reset so the file never sees a write the pointers will not account for.
  assign rf_wr_e    = push & ~rst_b;
  assign rf_wr_addr = wptr;
  assign rf_wr_data = in_data;
  assign rf_rd_addr = rptr;
  assign out_data   = rf_rd_data;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_regfl_fifo_ctrl.sv
// Bench for regfl_fifo_ctrl: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based FIFO model.
module tb_regfl_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          rf_wr_e;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic [AW-1:0] rf_rd_addr;
  logic [DW-1:0] rf_rd_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  always #5 clk = ~clk;

  regfl_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_b(rst_b),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .rf_wr_e(rf_wr_e), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .count(count), .full(full), .empty(empty)
  );

  // 4x8 register file as the integrating top would provide it
  logic [DW-1:0] rf_mem [4];
  always @(posedge clk) if (rf_wr_e) rf_mem[rf_wr_addr] <= rf_wr_data;
  assign rf_rd_data = rf_mem[rf_rd_addr];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a queue of stored bytes plus a running push tally for the write slot.
  byte unsigned q[$];
  int           wcnt;
  logic         m_push, m_pop, m_rst;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic apply(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
    @(negedge clk);
    rst_b = r; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    m_rst  = r;
    m_push = !r && iv && (q.size() < 4);
    m_pop  = !r && ordy && (q.size() > 0);
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == 4));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() != 4));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("rf_wr_e", 32'(rf_wr_e), 32'(m_push));
    if (m_push) begin
      chk("rf_wr_addr", 32'(rf_wr_addr), 32'(wcnt % 4));
      chk("rf_wr_data", 32'(rf_wr_data), 32'(d));
    end
    if (q.size() > 0) chk("out_data", 32'(out_data), 32'(q[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_rst) begin
      q.delete();
      wcnt = 0;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        q.push_back(in_data);
        wcnt++;
      end
    end
  endtask

  typedef struct {
    logic       rst, iv;
    logic [7:0] d;
    logic       ordy;
    logic [2:0] cnt;
    logic       full, empty, ov;
    logic [7:0] od;
    logic       wr_e;
    logic [1:0] wa;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic iv, input logic [7:0] d, input logic ordy,
                              input logic [2:0] c, input logic f, input logic e, input logic ov,
                              input logic [7:0] od, input logic we, input logic [1:0] wa);
    vec_t v;
    v.rst = r; v.iv = iv; v.d = d; v.ordy = ordy; v.cnt = c; v.full = f; v.empty = e;
    v.ov = ov; v.od = od; v.wr_e = we; v.wa = wa;
    return v;
  endfunction

  vec_t        tbl [13];
  byte unsigned popped[$];
  byte unsigned exp_pop[$];

  initial begin
    for (int i = 0; i < 4; i++) rf_mem[i] = '0;
    rst_b = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    q.delete(); wcnt = 0;

    // Fill to full, hold a blocked byte, drain in order, then single-push latency.
    tbl[0]  = mk(1'b0, 1'b1, 8'hA1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0);
    tbl[1]  = mk(1'b0, 1'b1, 8'hB2, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 2'd1);
    tbl[2]  = mk(1'b0, 1'b1, 8'hC3, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 2'd2);
    tbl[3]  = mk(1'b0, 1'b1, 8'hD4, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 2'd3);
    tbl[4]  = mk(1'b0, 1'b1, 8'hE5, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 2'd0);
    tbl[5]  = mk(1'b0, 1'b1, 8'hE5, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 2'd0);
    tbl[6]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 2'd0);
    tbl[7]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 2'd0);
    tbl[8]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 2'd0);
    tbl[9]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 8'hD4, 1'b0, 2'd0);
    tbl[10] = mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
    tbl[11] = mk(1'b0, 1'b1, 8'h5A, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0);
    tbl[12] = mk(1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 2'd1);

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk("vec_count", 32'(count), 32'(tbl[i].cnt));
      chk("vec_full", 32'(full), 32'(tbl[i].full));
      chk("vec_empty", 32'(empty), 32'(tbl[i].empty));
      chk("vec_out_valid", 32'(out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) chk("vec_out_data", 32'(out_data), 32'(tbl[i].od));
      chk("vec_rf_wr_e", 32'(rf_wr_e), 32'(tbl[i].wr_e));
      chk("vec_rf_wr_addr", 32'(rf_wr_addr), 32'(tbl[i].wa));
      tick();
    end

    // Steady push+pop at count=2 across several pointer wraps.
    apply(1'b1, 1'b0, 8'h00, 1'b0); tick();
    apply(1'b0, 1'b1, 8'h11, 1'b0); tick();
    apply(1'b0, 1'b1, 8'h22, 1'b0); tick();
    popped.delete();
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b1, 8'(i), 1'b1);
      if (out_valid) popped.push_back(out_data);
      tick();
    end
    apply(1'b0, 1'b0, 8'h00, 1'b0);
    chk("stream_count", 32'(count), 32'd2);
    exp_pop = '{8'h11, 8'h22, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    chk("stream_len", 32'(popped.size()), 32'd10);
    for (int i = 0; i < 10 && i < popped.size(); i++) chk("stream_order", 32'(popped[i]), 32'(exp_pop[i]));
    tick();

    // Full with push and pop together: only the pop happens, freed slot takes 77 next.
    apply(1'b1, 1'b0, 8'h00, 1'b0); tick();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0); tick();
    end
    apply(1'b0, 1'b1, 8'h77, 1'b1);
    chk("full_no_push", 32'(rf_wr_e), 32'd0);
    tick();
    apply(1'b0, 1'b1, 8'h77, 1'b0);
    chk("freed_ready", 32'(in_ready), 32'd1);
    chk("freed_wr_e", 32'(rf_wr_e), 32'd1);
    chk("freed_addr", 32'(rf_wr_addr), 32'd0);
    chk("freed_count", 32'(count), 32'd3);
    tick();

    // Reset mid-stream wins over simultaneous push/pop.
    apply(1'b0, 1'b0, 8'h00, 1'b1); tick();
    apply(1'b1, 1'b1, 8'h99, 1'b1);
    chk("rst_wr_e", 32'(rf_wr_e), 32'd0);
    tick();
    apply(1'b0, 1'b1, 8'h42, 1'b0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_next_addr", 32'(rf_wr_addr), 32'd0);
    tick();

    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfl_fifo_ctrl.md
Name: regfl_fifo_ctrl

Overview:
- Upstream sequencer that turns the 4x8 register file into a 4-entry FIFO.
- Accepts bytes on a valid/ready input stream and drives the file's write port (write enable, write address, write data).
- Drives the file's read address, takes its combinational read data back, and presents it on a valid/ready output stream.
- Sits between the byte producer and the register file; the file instance lives in the integrating top.

Parameters:
- DW, 8: data width; matches the register file word.
- AW, 2: address width; depth = 2**AW = 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_b  in  1  reset; synchronous, active-high.
- in_valid  in  1  producer has a byte on in_data.
- in_data  in  DW  byte to enqueue.
- in_ready  out  1  controller can accept a byte this cycle.
- out_valid  out  1  out_data holds the oldest stored byte.
- out_data  out  DW  oldest byte.
- out_ready  in  1  consumer takes out_data this cycle.
- rf_wr_e  out  1  register file write enable.
- rf_wr_addr  out  AW  register file write address.
- rf_wr_data  out  DW  register file write data.
- rf_rd_addr  out  AW  register file read address.
- rf_rd_data  in  DW  register file read data; combinational from rf_rd_addr.
- count  out  AW+1  number of stored entries, 0..4.
- full  out  1  count == 4.
- empty  out  1  count == 0.

Behaviour:
- State: wptr[AW-1:0], rptr[AW-1:0], count[AW:0], all registered.
- Reset (rst_b=1 at a clock edge): wptr=0, rptr=0, count=0.
  - Outputs after reset: empty=1, full=0, in_ready=1, out_valid=0, rf_wr_e=0.
  - Reset has priority over push/pop in the same cycle.
  - Reset mid-operation discards all stored entries. File contents are not cleared and are never exposed, because out_valid=0.
- Decoded outputs (combinational from registered state): in_ready = ~full; out_valid = ~empty; full = (count==4); empty = (count==0).
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- Write port, combinational:
  - rf_wr_e = push (0 while rst_b=1).
  - rf_wr_addr = wptr.
  - rf_wr_data = in_data.
  - The file captures the byte on the same edge that advances wptr.
- Read port, combinational:
  - rf_rd_addr = rptr.
  - out_data = rf_rd_data.
  - out_data must be stable while out_valid=1 and out_ready=0.
- On each edge:
  - push: wptr <= wptr+1, wrapping 3 -> 0.
  - pop: rptr <= rptr+1, wrapping 3 -> 0.
  - count: push only -> +1; pop only -> -1; both or neither -> unchanged.
- Latency: a byte pushed at edge N is visible on out_data with out_valid=1 after edge N. There is no same-cycle bypass from in_data to out_data.
- Full: in_ready=0, so no push even if pop is asserted in the same cycle. A pop while full frees a slot; in_ready=1 on the next cycle.
- Empty: out_valid=0, so out_ready is ignored and there is no pop. An in_valid while empty enqueues normally.
- Push and pop together with 1 <= count <= 3: both pointers advance and count is held. The written slot is never the slot being read, since wptr != rptr when 0 < count < 4.
- Held input: the producer holds in_data and in_valid while in_ready=0. The controller does not latch a byte it has not accepted.
- Invariant: count == (wptr - rptr) mod 4, except count=4 when wptr==rptr and full.

Test Plan:
- Reset, then out_ready=0; push A1, B2, C3, D4 on consecutive cycles -> rf_wr_addr 0,1,2,3; count 1..4; full=1; in_ready=0. Hold E5 on in_valid -> rf_wr_e stays 0 and count stays 4.
- From that full state, out_ready=1 for 4 cycles -> out_data A1, B2, C3, D4 in order; then empty=1, out_valid=0, count=0.
- Empty, push 5A at edge N -> out_valid=0 before edge N; out_valid=1 with out_data=5A after edge N.
- count=2, then in_valid=1 and out_ready=1 for 10 cycles with data 00..09 -> count stays 2. Both pointers wrap 3 -> 0 at least twice. Output order is the two pre-loaded bytes, then 00..07.
- Full with in_valid=1 (data 77) and out_ready=1 -> pop only, count=3. Next cycle in_ready=1 and 77 is written to the freed address.
- count=3 mid-stream, assert rst_b for one edge together with in_valid and out_ready -> count=0, empty=1, out_valid=0, rf_wr_e=0 that cycle. Next push is written to address 0.
